// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
// Imported by mdu_ctrl; mdu_sign_adj is width-parameterised and needs none of it.
package mdu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   localparam logic MDU_OP_MULTU = 1'b0;
   localparam logic MDU_OP_MULT  = 1'b1;

   localparam int unsigned OPND_W = 32;
   localparam int unsigned PROD_W = 64;

   // A one-cycle hold still needs a 1-bit counter so the vector is never empty.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mdu_sign_adj.sv
// Conditional two's complement negate.
// Used as abs() on operand entry and as product negate on exit.
module mdu_sign_adj #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle sequencer around an external unsigned 32x32 multiplier.
// Holds magnitudes on mul_a/mul_b for MUL_CYCLES cycles, then writes the signed-corrected product into HI/LO.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_signed,
   input  logic [OPND_W-1:0] rs_val,
   input  logic [OPND_W-1:0] rt_val,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [OPND_W-1:0] wdata,
   output logic [OPND_W-1:0] mul_a,
   output logic [OPND_W-1:0] mul_b,
   input  logic [PROD_W-1:0] mul_z,
   output logic              busy,
   output logic              done,
   output logic [OPND_W-1:0] hi,
   output logic [OPND_W-1:0] lo
);

   localparam int unsigned     CNT_W    = cnt_width(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

   mdu_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q;
   logic [OPND_W-1:0] mul_a_q, mul_b_q;
   logic [OPND_W-1:0] hi_q, lo_q;
   logic              done_q;

   logic              is_mult;
   logic [OPND_W-1:0] mul_a_d, mul_b_d;
   logic              neg_d;
   logic [PROD_W-1:0] prod_d;

   assign is_mult = (op_signed == MDU_OP_MULT);
   assign neg_d   = is_mult & (rs_val[OPND_W-1] ^ rt_val[OPND_W-1]);

   mdu_sign_adj #(.W(OPND_W)) u_abs_a (
      .val_i (rs_val),
      .neg_i (is_mult & rs_val[OPND_W-1]),
      .res_o (mul_a_d)
   );

   mdu_sign_adj #(.W(OPND_W)) u_abs_b (
      .val_i (rt_val),
      .neg_i (is_mult & rt_val[OPND_W-1]),
      .res_o (mul_b_d)
   );

   // Product magnitude is at most 2^62, so the 64-bit negate cannot overflow.
   mdu_sign_adj #(.W(PROD_W)) u_neg_prod (
      .val_i (mul_z),
      .neg_i (neg_q),
      .res_o (prod_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // start outranks MTHI/MTLO; operands stay put otherwise to avoid toggling the array.
               if (start) begin
                  mul_a_q <= mul_a_d;
                  mul_b_q <= mul_b_d;
                  neg_q   <= neg_d;
                  cnt_q   <= CNT_LOAD;
                  state_q <= RUN;
               end else begin
                  if (mthi) hi_q <= wdata;
                  if (mtlo) lo_q <= wdata;
               end
            end
            RUN: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  {hi_q, lo_q} <= prod_d;
                  done_q       <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;
   assign busy  = (state_q == RUN);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: a 4-cycle instance and a 1-cycle instance, each with a behavioural multiplier.
// Expected HI:LO values come from a sign-extend-and-multiply model queued at issue time.
module tb_mdu_ctrl;

   localparam int unsigned W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- 4-cycle instance ----------------
   logic          start = 1'b0, op_signed = 1'b0, mthi = 1'b0, mtlo = 1'b0;
   logic [W-1:0]  rs_val = '0, rt_val = '0, wdata = '0;
   logic [W-1:0]  mul_a, mul_b, hi, lo;
   logic [63:0]   mul_z;
   logic          busy, done;

   assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

   mdu_ctrl #(.MUL_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
      .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // ---------------- 1-cycle instance ----------------
   logic          start1 = 1'b0, op1 = 1'b0;
   logic [W-1:0]  rs1 = '0, rt1 = '0;
   logic          mthi1 = 1'b0, mtlo1 = 1'b0;
   logic [W-1:0]  wdata1 = '0;
   logic [W-1:0]  mul_a1, mul_b1, hi1, lo1;
   logic [63:0]   mul_z1;
   logic          busy1, done1;

   assign mul_z1 = {32'd0, mul_a1} * {32'd0, mul_b1};

   mdu_ctrl #(.MUL_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .op_signed(op1),
      .rs_val(rs1), .rt_val(rt1), .mthi(mthi1), .mtlo(mtlo1), .wdata(wdata1),
      .mul_a(mul_a1), .mul_b(mul_b1), .mul_z(mul_z1),
      .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
   );

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   logic [63:0] exp1_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] xa, xb;
      xa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      xb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return xa * xb;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) check_val("spurious_done", 1, 0);
         else check_val("hilo", {hi, lo}, exp_q.pop_front());
      end
      if (!rst && done1) begin
         if (exp1_q.size() == 0) check_val("spurious_done1", 1, 0);
         else check_val("hilo1", {hi1, lo1}, exp1_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; the next edge samples the start.
   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mtlo);
      start     = 1'b1;
      op_signed = sgn;
      rs_val    = a;
      rt_val    = b;
      mtlo      = with_mtlo;
      wdata     = 32'hDEAD_BEEF;
      exp_q.push_back(model(sgn, a, b));
   endtask

   // Walks the cycles after an issue, checking busy/done; optional mid-run pokes.
   task automatic track(input int lat, input bit poke);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
         if (poke && k == 2) begin
            start = 1'b1; op_signed = 1'b0; rs_val = 32'h0000_0100; rt_val = 32'h0000_0100;
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
         end
         if (poke && k == 3) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
         check_val($sformatf("busy_k%0d", k), busy, (k < lat));
         check_val($sformatf("done_k%0d", k), done, (k == lat));
      end
   endtask

   task automatic issue1(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      start1 = 1'b1; op1 = sgn; rs1 = a; rt1 = b;
      exp1_q.push_back(model(sgn, a, b));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ndone;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_hi", hi, 0);
      check_val("rst_lo", lo, 0);
      check_val("rst_mul_a", mul_a, 0);
      check_val("rst_mul_b", mul_b, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); track(5, 0);
      issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); track(5, 0);
      issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); track(5, 0);
      issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0); track(5, 0);
      issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0); track(5, 0);
      check_val("done_hi", hi, 32'hFFFF_FFFF);
      check_val("done_lo", lo, 32'h8000_0000);

      // MTHI, then MTHI+MTLO together
      @(posedge clk); #1;
      mthi = 1'b1; wdata = 32'h1234_5678;
      @(posedge clk); #1;
      mthi = 1'b0;
      check_val("mthi_hi", hi, 32'h1234_5678);
      check_val("mthi_lo_kept", lo, 32'h8000_0000);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      check_val("mtboth_hi", hi, 32'h0BAD_F00D);
      check_val("mtboth_lo", lo, 32'h0BAD_F00D);

      // start with MTLO in the same cycle: product wins
      issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1); track(5, 0);
      // pokes mid-run must not disturb the result
      issue(1'b0, 32'h0001_0001, 32'h0000_FFFF, 1'b0); track(5, 1);
      // back-to-back: the done cycle issues the next one
      issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0); track(5, 0);
      issue(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0); track(5, 0);

      for (int i = 0; i < 6; i++) begin
         issue(1'(($urandom_range(0, 1))), $urandom, $urandom, 1'b0);
         track(5, 0);
      end

      // reset during RUN aborts
      @(posedge clk); #1;
      issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("abort_busy", busy, 0);
      check_val("abort_hi", hi, 0);
      check_val("abort_lo", lo, 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check_val("abort_no_done", ndone, 0);

      // MUL_CYCLES=1 back-to-back
      issue1(1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
      for (int op = 0; op < 3; op++) begin
         for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 1'b0;
            check_val($sformatf("c1_busy_k%0d", k), busy1, (k == 1));
            check_val($sformatf("c1_done_k%0d", k), done1, (k == 2));
         end
         if (op < 2) issue1(1'(op), 32'h8000_0000 + 32'(op), 32'hFFFF_FF00);
      end

      repeat (3) @(posedge clk);
      #1;
      check_val("q_empty", 64'(exp_q.size()), 0);
      check_val("q1_empty", 64'(exp1_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected end before 100000ns");
      $fatal(1);
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle sequencer for the unsigned 32x32 combinational multiplier in the MIPS CPU execute stage.
- Latches operands and holds them stable on the multiplier inputs for MUL_CYCLES cycles, which makes a multicycle timing path legal.
- Adds signed MULT support by sign-magnitude conversion around the unsigned array.
- Owns the architectural HI/LO registers, including MTHI/MTLO writes, and drives a busy stall to the pipeline.

Parameters:
- MUL_CYCLES, 4, cycles the multiplier inputs are held before the product is sampled. Legal range 1..16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  issue MULT/MULTU this cycle
- op_signed  in  1  1 = MULT (signed), 0 = MULTU
- rs_val  in  32  operand a
- rt_val  in  32  operand b
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- mul_a  out  32  registered magnitude of a, to multiplier input a
- mul_b  out  32  registered magnitude of b, to multiplier input b
- mul_z  in  64  unsigned product from the multiplier
- busy  out  1  multiply in flight; pipeline must stall MFHI/MFLO/MULT/MTxx
- done  out  1  one-cycle pulse; HI/LO hold the new product this cycle
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst=1 at a rising edge) forces state=IDLE, cnt=0, neg=0, mul_a=0, mul_b=0, hi=0, lo=0, done=0, busy=0. Reset wins over every other input.
- busy is the decoded state (state==RUN), not a separately registered flag.
- States: IDLE, RUN.
- IDLE with start=1:
  - mul_a <= (op_signed & rs_val[31]) ? -rs_val : rs_val. mul_b is the same for rt_val.
  - neg <= op_signed & (rs_val[31] ^ rt_val[31]).
  - cnt <= MUL_CYCLES-1; state <= RUN.
- RUN with cnt!=0: cnt <= cnt-1. mul_a and mul_b are held unchanged.
- RUN with cnt==0:
  - {hi,lo} <= neg ? -mul_z : mul_z, computed as a 64-bit two's complement negate.
  - done <= 1; state <= IDLE.
- done is 0 in every cycle other than the one following product capture.
- Timing: start sampled at the end of cycle T gives busy=1 for cycles T+1..T+MUL_CYCLES, and done=1 with the new hi/lo in cycle T+MUL_CYCLES+1, when busy=0.
  - For MUL_CYCLES=1: busy for one cycle, result in T+2.
- Width rules:
  - Magnitude of 0x80000000 is 0x80000000, which fits unsigned 32 bits; no overflow case exists.
  - Unsigned product of magnitudes is at most 2^62, so the negate never overflows 64 bits.
  - cnt width is clog2(MUL_CYCLES).
- MTHI/MTLO in IDLE with start=0: hi <= wdata (mthi) and/or lo <= wdata (mtlo) at the next edge. Both may be set together.
- Simultaneous events in IDLE: start has priority; mthi/mtlo in the same cycle are dropped.
- In RUN, start, mthi and mtlo are ignored with no side effects. The pipeline guarantees a stall on busy.
- Back-to-back: start in the done cycle is accepted; the new operation begins that edge.
- Reset mid-RUN aborts the operation: hi/lo return to 0, no done pulse.
- mul_a and mul_b retain their last values in IDLE (no toggling, saves power).

Decomposition:
- Package mdu_pkg:
  - state enum {IDLE, RUN}
  - constants MDU_OP_MULTU=0, MDU_OP_MULT=1
  - 64-bit product width constant
- Sub-module mdu_sign_adj (combinational): 32-bit conditional abs for operand entry, and 64-bit conditional negate for product exit. Instantiated once for each direction.
- The multiplier itself stays outside mdu_ctrl and is wired at the execute-stage level.

Test Plan:
The bench instantiates the multiplier on mul_a/mul_b/mul_z; MUL_CYCLES=4 unless stated.
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start in cycle T -> busy=1 in T+1..T+4; done in T+5 with hi=0xFFFFFFFE, lo=0x00000001.
2. MULT 0xFFFFFFFF (-1) x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands as MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
3. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000 x 0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
4. Inputs while busy and simultaneous events:
   - mthi=1, wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle.
   - start plus mtlo=1 in the same IDLE cycle -> mtlo dropped, lo = product.
   - start and mthi pulsed mid-RUN -> no effect; the original result is unchanged.
5. Back-to-back: second start in the done cycle -> second done exactly 5 cycles later. Repeat with MUL_CYCLES=1 -> done 2 cycles after each start.
6. rst=1 in T+2 of a MULT -> busy=0 and hi=lo=0 in T+3; no done pulse in the following 10 cycles.
